led_cube_frame_scanner: RTL and testbench
=========================================

LED_CUBE_FRAME_SCANNER -- requirements
Module: led_cube_frame_scanner

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 8: layer count (>=2).
REQ-002 SHALL have parameter NUM_LATCHES, default 8: latches per layer (>=2).
REQ-003 SHALL have parameter DATA_W, default 8: latch data width.
REQ-004 SHALL have parameter DWELL_W, default 16: dwell counter width.
REQ-005 SHALL derive ADDR_W = $clog2(NUM_LAYERS*NUM_LATCHES) locally.
REQ-006 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  in  1  pulse; begin scanning when idle.
REQ-009 SHALL have port stop  in  1  pulse; finish current frame, then idle.
REQ-010 SHALL have port continuous  in  1  1 = repeat frames until stop; 0 = one frame.
REQ-011 SHALL have port scan_up  in  1  0 = layers high-to-low, 1 = low-to-high; sampled at frame start.
REQ-012 SHALL have port dwell_cycles  in  DWELL_W  layer on-time; sampled on DRIVE entry.
REQ-013 SHALL have port rd_addr  out  ADDR_W  pattern memory address = layer*NUM_LATCHES + latch.
REQ-014 SHALL have port rd_data  in  DATA_W  pattern data, valid one cycle after rd_addr.
REQ-015 SHALL have port data  out  DATA_W  shared latch data bus.
REQ-016 SHALL have port latches  out  NUM_LATCHES  one-hot latch strobes, active-high.
REQ-017 SHALL have port layers  out  NUM_LAYERS  one-hot layer enables, active-high.
REQ-018 SHALL have ports busy  out  1 (not IDLE) and frame_done  out  1 (one-cycle pulse per completed frame).

Function
REQ-019 SHALL implement states IDLE, ADDR, CAPTURE, STROBE, DRIVE.
REQ-020 IDLE->ADDR on start; layer index := NUM_LAYERS-1 (scan_up=0) or 0 (scan_up=1); latch index := 0; start while busy ignored.
REQ-021 ADDR: rd_addr driven for current layer/latch; next CAPTURE.
REQ-022 CAPTURE: data <= rd_data; next STROBE.
REQ-023 STROBE: latches[latch]=1 for exactly one cycle with data stable; next ADDR with latch+1, or DRIVE after latch NUM_LATCHES-1.
REQ-024 Load of one layer SHALL take exactly 3*NUM_LATCHES cycles; latches zero outside STROBE.
REQ-025 layers SHALL be all-zero in every state except DRIVE (blanking during load).
REQ-026 DRIVE: layers one-hot at current layer for max(dwell_cycles,1) cycles.
REQ-027 DRIVE exit, not last layer: step layer by scan direction, latch := 0, go ADDR.
REQ-028 DRIVE exit, last layer: frame_done=1 for that cycle; go ADDR (new frame, reload start layer, resample scan_up) if continuous=1 and no stop pending, else IDLE.
REQ-029 stop while busy SHALL set stop_pending, cleared on IDLE entry; stop in IDLE ignored.
REQ-030 start and stop in same IDLE cycle SHALL run exactly one frame.
REQ-031 continuous SHALL be evaluated only at frame end; mid-frame changes have no effect on the current frame.
REQ-032 Frame period SHALL be sum over layers of (3*NUM_LATCHES + max(dwell,1)) cycles, no idle gaps.
REQ-033 Layer/latch counters SHALL never exceed NUM_LAYERS-1 / NUM_LATCHES-1, including non-power-of-two parameters.

Reset
REQ-034 rst SHALL force IDLE; layers, latches, data, rd_addr, busy, frame_done, stop_pending, counters = 0.
REQ-035 rst asserted mid-frame SHALL take effect next edge; no partial strobe or layer enable after it.

Structure
REQ-036 Package led_cube_pkg SHALL hold the state enum and default parameter constants.
REQ-037 Dwell countdown SHALL be sub-module led_cube_dwell_timer (load, count, expire pulse).

Verification
REQ-038 Defaults, dwell=4, continuous=0, scan_up=0, start: layers enable 7..0, 28 cycles each, frame_done once at cycle 224, then IDLE.
REQ-039 Memory model rd_data=addr: latch j strobe of layer L sees data = L*8+j; exactly one strobe per latch per layer.
REQ-040 continuous=1, stop during frame 2 layer 3: frame 2 completes, two frame_done pulses total, IDLE.
REQ-041 dwell_cycles=0: each DRIVE lasts 1 cycle; scan_up=1 gives layers 0..7.
REQ-042 NUM_LAYERS=5, NUM_LATCHES=3: rd_addr max 14, no out-of-range index; rst mid-DRIVE: all outputs 0 next cycle.

Source files
------------

// File: rtl/led_cube_pkg.sv
// Shared state encoding and default sizing for the LED cube frame scanner.
package led_cube_pkg;

    localparam int unsigned DefNumLayers  = 8;
    localparam int unsigned DefNumLatches = 8;
    localparam int unsigned DefDataW      = 8;
    localparam int unsigned DefDwellW     = 16;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCapture,
        StStrobe,
        StDrive
    } scan_state_e;

endpackage

// File: rtl/led_cube_frame_scanner_if.sv
// Pattern-memory read port plus the latch/layer drive bus of the cube.
interface led_cube_frame_scanner_if #(
    parameter int unsigned NUM_LAYERS  = led_cube_pkg::DefNumLayers,
    parameter int unsigned NUM_LATCHES = led_cube_pkg::DefNumLatches,
    parameter int unsigned DATA_W      = led_cube_pkg::DefDataW
);
    localparam int unsigned ADDR_W = $clog2(NUM_LAYERS * NUM_LATCHES);

    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic [DATA_W-1:0]      data;
    logic [NUM_LATCHES-1:0] latches;
    logic [NUM_LAYERS-1:0]  layers;

    modport master (output rd_addr, data, latches, layers, input rd_data);
    modport slave  (input rd_addr, data, latches, layers, output rd_data);
endinterface

// File: rtl/led_cube_dwell_timer.sv
// Layer on-time countdown: load max(dwell,1), count down, pulse on the final cycle.
module led_cube_dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               expire_o
);
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == DWELL_W'(1));
endmodule

// File: rtl/led_cube_frame_scanner.sv
// Multiplexed LED cube scanner: loads each layer's latches from pattern memory
// with the layers blanked, then enables that layer for a programmable dwell.
module led_cube_frame_scanner
    import led_cube_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = DefNumLayers,
    parameter int unsigned NUM_LATCHES = DefNumLatches,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned DWELL_W     = DefDwellW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic               scan_up,
    input  logic [DWELL_W-1:0] dwell_cycles,
    output logic               busy,
    output logic               frame_done,
    led_cube_frame_scanner_if.master bus
);
    localparam int unsigned ADDR_W  = $clog2(NUM_LAYERS * NUM_LATCHES);
    localparam int unsigned LAYER_W = $clog2(NUM_LAYERS);
    localparam int unsigned LATCH_W = $clog2(NUM_LATCHES);
    localparam logic [LAYER_W-1:0] LastLayer = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [LATCH_W-1:0] LastLatch = LATCH_W'(NUM_LATCHES - 1);

    scan_state_e            state_q, state_d;
    logic [LAYER_W-1:0]     layer_q, layer_d;
    logic [LATCH_W-1:0]     latch_q, latch_d;
    logic                   up_q, up_d;
    logic                   stop_pending_q, stop_pending_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [NUM_LATCHES-1:0] latches_q, latches_d;
    logic [NUM_LAYERS-1:0]  layers_q, layers_d;
    logic                   busy_q, busy_d;
    logic                   dwell_load, dwell_expire, last_layer;

    assign last_layer = up_q ? (layer_q == LastLayer) : (layer_q == '0);
    assign dwell_load = (state_q == StStrobe) && (latch_q == LastLatch);

    led_cube_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (dwell_load),
        .dwell_i  (dwell_cycles),
        .expire_o (dwell_expire)
    );

    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        latch_d        = latch_q;
        up_d           = up_q;
        stop_pending_d = stop_pending_q;
        data_d         = data_q;
        unique case (state_q)
            StIdle: if (start) begin
                state_d        = StAddr;
                up_d           = scan_up;
                layer_d        = scan_up ? '0 : LastLayer;
                latch_d        = '0;
                stop_pending_d = stop;
            end
            StAddr:    state_d = StCapture;
            StCapture: begin
                data_d  = bus.rd_data;
                state_d = StStrobe;
            end
            StStrobe: begin
                if (latch_q == LastLatch) begin
                    state_d = StDrive;
                end else begin
                    latch_d = latch_q + LATCH_W'(1);
                    state_d = StAddr;
                end
            end
            StDrive: if (dwell_expire) begin
                latch_d = '0;
                if (!last_layer) begin
                    layer_d = up_q ? layer_q + LAYER_W'(1) : layer_q - LAYER_W'(1);
                    state_d = StAddr;
                end else if (continuous && !stop_pending_q && !stop) begin
                    up_d    = scan_up;
                    layer_d = scan_up ? '0 : LastLayer;
                    state_d = StAddr;
                end else begin
                    layer_d        = '0;
                    stop_pending_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A stop arriving on the frame's final cycle still ends it; pending clears on idle entry.
        if (state_q != StIdle && state_d != StIdle && stop) stop_pending_d = 1'b1;

        rd_addr_d = rd_addr_q;
        if (state_d == StAddr) begin
            rd_addr_d = ADDR_W'(layer_d) * ADDR_W'(NUM_LATCHES) + ADDR_W'(latch_d);
        end
        latches_d = (state_d == StStrobe) ? (NUM_LATCHES'(1) << latch_d) : '0;
        layers_d  = (state_d == StDrive) ? (NUM_LAYERS'(1) << layer_d) : '0;
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            layer_q        <= '0;
            latch_q        <= '0;
            up_q           <= 1'b0;
            stop_pending_q <= 1'b0;
            rd_addr_q      <= '0;
            data_q         <= '0;
            latches_q      <= '0;
            layers_q       <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            layer_q        <= layer_d;
            latch_q        <= latch_d;
            up_q           <= up_d;
            stop_pending_q <= stop_pending_d;
            rd_addr_q      <= rd_addr_d;
            data_q         <= data_d;
            latches_q      <= latches_d;
            layers_q       <= layers_d;
            busy_q         <= busy_d;
        end
    end

    assign frame_done  = (state_q == StDrive) && dwell_expire && last_layer;
    assign busy        = busy_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.data    = data_q;
    assign bus.latches = latches_q;
    assign bus.layers  = layers_q;
endmodule

// File: tb/tb_led_cube_frame_scanner.sv
// Bench: an 8x8 and a 5x3 scanner share stimulus and are checked each cycle
// against a frame-position model (cycle offset -> layer slot, latch, phase).
module tb_led_cube_frame_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, continuous = 1'b0, scan_up = 1'b0;
    logic [15:0] dwell = 16'd4;
    logic        busy0, busy1, fd0, fd1;

    int n_chk = 0, n_fail = 0, fd_cnt0 = 0, max_addr1 = 0;
    bit chk_en = 1'b0;

    // Model: per DUT, active flag, cycle offset inside the frame, direction, dwell, stop pending.
    bit m_act [2];
    bit m_up  [2];
    bit m_pend[2];
    int m_t   [2];
    int m_dw  [2];

    always #5 clk = ~clk;

    led_cube_frame_scanner_if #(.NUM_LAYERS(8), .NUM_LATCHES(8), .DATA_W(8)) bus0 ();
    led_cube_frame_scanner_if #(.NUM_LAYERS(5), .NUM_LATCHES(3), .DATA_W(8)) bus1 ();

    led_cube_frame_scanner #(.NUM_LAYERS(8), .NUM_LATCHES(8), .DATA_W(8), .DWELL_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .scan_up(scan_up), .dwell_cycles(dwell), .busy(busy0), .frame_done(fd0), .bus(bus0)
    );
    led_cube_frame_scanner #(.NUM_LAYERS(5), .NUM_LATCHES(3), .DATA_W(8), .DWELL_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .scan_up(scan_up), .dwell_cycles(dwell), .busy(busy1), .frame_done(fd1), .bus(bus1)
    );

    // Synchronous pattern memories with contents equal to the address.
    always @(posedge clk) begin
        bus0.rd_data <= {2'b00, bus0.rd_addr};
        bus1.rd_data <= {4'b0000, bus1.rd_addr};
    end

    function automatic int nl_of(input int d);
        return (d == 0) ? 8 : 5;
    endfunction
    function automatic int nlat_of(input int d);
        return (d == 0) ? 8 : 3;
    endfunction
    function automatic int frame_len(input int d, input int dw);
        return nl_of(d) * (3 * nlat_of(d) + dw);
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", nm, d, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d]  <= 1'b0;
                m_pend[d] <= 1'b0;
            end else if (!m_act[d]) begin
                if (start) begin
                    m_act[d]  <= 1'b1;
                    m_t[d]    <= 0;
                    m_up[d]   <= scan_up;
                    m_dw[d]   <= (dwell == 16'd0) ? 1 : int'(dwell);
                    m_pend[d] <= stop;
                end
            end else begin
                if (stop) m_pend[d] <= 1'b1;
                if (m_t[d] == frame_len(d, m_dw[d]) - 1) begin
                    if (continuous && !m_pend[d] && !stop) begin
                        m_t[d]  <= 0;
                        m_up[d] <= scan_up;
                    end else begin
                        m_act[d]  <= 1'b0;
                        m_pend[d] <= 1'b0;
                    end
                end else begin
                    m_t[d] <= m_t[d] + 1;
                end
            end
        end
    end

    task automatic check_dut(input int d, input int lay, input int lat, input int addr,
                             input int dat, input bit bsy, input bit fdn);
        int nl, nlat, p, k, r, l, j, e_lay, e_lat;
        bit e_fd;
        nl = nl_of(d); nlat = nlat_of(d);
        e_lay = 0; e_lat = 0; e_fd = 1'b0;
        if (m_act[d]) begin
            p = 3 * nlat + m_dw[d];
            k = m_t[d] / p;
            r = m_t[d] % p;
            l = m_up[d] ? k : nl - 1 - k;
            e_fd = (m_t[d] == nl * p - 1);
            if (r < 3 * nlat) begin
                j = r / 3;
                if (r % 3 == 0) chk("rd_addr", d, addr, l * nlat + j);
                if (r % 3 == 2) begin
                    e_lat = 1 << j;
                    chk("strobe_data", d, dat, (l * nlat + j) % 256);
                end
            end else begin
                e_lay = 1 << l;
            end
        end
        chk("layers", d, lay, e_lay);
        chk("latches", d, lat, e_lat);
        chk("busy", d, int'(bsy), int'(m_act[d]));
        chk("frame_done", d, int'(fdn), int'(e_fd));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, int'(bus0.layers), int'(bus0.latches), int'(bus0.rd_addr),
                      int'(bus0.data), busy0, fd0);
            check_dut(1, int'(bus1.layers), int'(bus1.latches), int'(bus1.rd_addr),
                      int'(bus1.data), busy1, fd1);
            if (fd0) fd_cnt0 <= fd_cnt0 + 1;
            if (int'(bus1.rd_addr) > max_addr1) max_addr1 <= int'(bus1.rd_addr);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while ((busy0 || busy1) && c < bound) begin
            @(negedge clk);
            c++;
        end
        if (busy0 || busy1) chk("idle_timeout", 0, int'(busy0 | busy1), 0);
        repeat (3) @(negedge clk);
    endtask

    // One frame on dut0 with literal layer expectations at two cycles and the done cycle.
    task automatic run_single(input int exp_len, input int ca, input int va,
                              input int cb, input int vb);
        int  f0;
        bit  found = 1'b0;
        f0 = fd_cnt0;
        pulse_start();
        for (int c = 1; c <= 600 && !found; c++) begin
            if (c == ca) chk("layers_at_a", 0, int'(bus0.layers), va);
            if (c == cb) chk("layers_at_b", 0, int'(bus0.layers), vb);
            if (fd0) begin
                found = 1'b1;
                chk("done_cycle", 0, c, exp_len);
            end else begin
                @(negedge clk);
            end
        end
        if (!found) chk("done_seen", 0, int'(fd0), 1);
        @(negedge clk);
        chk("idle_after_frame", 0, int'(busy0), 0);
        wait_idle(400);
        chk("done_pulses", 0, fd_cnt0 - f0, 1);
    endtask

    initial begin
        int f0;
        int c;
        rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_layers", 0, int'(bus0.layers), 0);
        chk("rst_latches", 0, int'(bus0.latches), 0);
        chk("rst_data", 0, int'(bus0.data), 0);
        chk("rst_rd_addr", 0, int'(bus0.rd_addr), 0);
        chk("rst_data", 1, int'(bus1.data), 0);
        chk("rst_rd_addr", 1, int'(bus1.rd_addr), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Defaults, dwell 4, top-down: 28 cycles per layer, done at 224.
        dwell = 16'd4; scan_up = 1'b0; continuous = 1'b0;
        run_single(224, 25, 'h80, 224, 'h01);

        // Dwell 0 behaves as 1, bottom-up.
        dwell = 16'd0; scan_up = 1'b1;
        run_single(200, 25, 'h01, 50, 'h02);

        // Continuous with stop in frame 2 while layer 3 is the current slot.
        dwell = 16'd4; scan_up = 1'b0; continuous = 1'b1;
        f0 = fd_cnt0;
        pulse_start();
        repeat (345) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(800);
        chk("stop_done_pulses", 0, fd_cnt0 - f0, 2);
        continuous = 1'b0;

        // Random control traffic; dwell only changes while both scanners are idle.
        for (int run = 0; run < 6; run++) begin
            dwell = 16'($urandom_range(0, 5));
            pulse_start();
            for (int i = 0; i < 500; i++) begin
                continuous = 1'($urandom_range(0, 1));
                scan_up    = 1'($urandom_range(0, 1));
                start      = ($urandom_range(0, 19) == 0);
                stop       = ($urandom_range(0, 59) == 0);
                @(negedge clk);
            end
            start = 1'b0; continuous = 1'b0; scan_up = 1'b0;
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            wait_idle(800);
        end

        // Reset while the small scanner drives a layer.
        dwell = 16'd6;
        pulse_start();
        c = 0;
        while (bus1.layers == '0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("drive_reached", 1, int'(bus1.layers != '0), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_layers", 1, int'(bus1.layers), 0);
        chk("rst_mid_latches", 1, int'(bus1.latches), 0);
        chk("rst_mid_busy", 1, int'(busy1), 0);
        chk("rst_mid_done", 1, int'(fd1), 0);
        chk("rst_mid_data", 1, int'(bus1.data), 0);
        chk("rst_mid_rd_addr", 1, int'(bus1.rd_addr), 0);
        chk("rst_mid_busy", 0, int'(busy0), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("max_rd_addr", 1, max_addr1, 14);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
